// File: rtl/slfifo_dir_arbiter.sv
// Purpose: owns the shared FX3 slave-FIFO bus, selecting read or write engine with turnaround gaps.
// Latency: grant 1 cycle after request in current direction, 1+TURN_CYCLES across a direction change.
// Backpressure: requests are level-held and ignored during a grant; released by done or watchdog.
module slfifo_dir_arbiter #(
   parameter int TURN_CYCLES      = 4,
   parameter int MAX_GRANT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic        rd_done,
   input  logic        wr_done,
   input  logic        timeout_clr,
   output logic        data_dir,
   output logic        rd_gnt,
   output logic        wr_gnt,
   output logic        busy,
   output logic        timeout,
   output logic [15:0] rd_grant_cnt,
   output logic [15:0] wr_grant_cnt
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_TURN     = 2'd1;
   localparam logic [1:0] S_GRANT_RD = 2'd2;
   localparam logic [1:0] S_GRANT_WR = 2'd3;

   // Counter reload values: turn counter counts down to zero, watchdog counts up to the last cycle.
   localparam logic [7:0]  TURN_LOAD = 8'(TURN_CYCLES - 1);
   localparam logic [15:0] WD_LAST   = 16'(MAX_GRANT_CYCLES - 1);

   logic [1:0]  state;
   logic        last_served;   // 0 = read engine, 1 = write engine
   logic        target;        // direction being turned toward while in TURN
   logic [7:0]  turn_cnt;
   logic [15:0] wd_cnt;

   logic pick;
   logic in_grant;
   logic cur_done;
   logic wd_expire;
   logic release_gnt;
   logic start_grant;
   logic grant_dir;

   // Arbitration choice plus this cycle's grant start / release decisions.
   always_comb begin
      pick        = (rd_req && wr_req) ? ~last_served : wr_req;
      in_grant    = (state == S_GRANT_RD) || (state == S_GRANT_WR);
      cur_done    = (state == S_GRANT_WR) ? wr_done : rd_done;
      wd_expire   = in_grant && !cur_done && (wd_cnt == WD_LAST);
      release_gnt = in_grant && (cur_done || wd_expire);
      grant_dir   = (state == S_IDLE) ? pick : target;
      start_grant = 1'b0;
      if (state == S_IDLE)
         start_grant = (rd_req || wr_req) && (pick == data_dir);
      else if (state == S_TURN)
         start_grant = (turn_cnt == 8'd0) && (target ? wr_req : rd_req);
   end

   // State machine, bus direction and turnaround countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         data_dir    <= 1'b0;
         target      <= 1'b0;
         turn_cnt    <= 8'd0;
         last_served <= 1'b1;
         busy        <= 1'b0;
      end else if (start_grant) begin
         state <= grant_dir ? S_GRANT_WR : S_GRANT_RD;
         busy  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               // Only reached with a request when the target differs from the bus direction.
               if (rd_req || wr_req) begin
                  target   <= pick;
                  data_dir <= pick;
                  turn_cnt <= TURN_LOAD;
                  state    <= S_TURN;
                  busy     <= 1'b1;
               end
            end
            S_TURN: begin
               // Final turn cycle without the target request falls back to IDLE, keeping data_dir.
               if (turn_cnt != 8'd0) begin
                  turn_cnt <= turn_cnt - 8'd1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               if (release_gnt) begin
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                  last_served <= (state == S_GRANT_WR);
               end
            end
         endcase
      end
   end

   // Grant outputs, per-grant watchdog count and wrapping grant counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_gnt       <= 1'b0;
         wr_gnt       <= 1'b0;
         wd_cnt       <= 16'd0;
         rd_grant_cnt <= 16'd0;
         wr_grant_cnt <= 16'd0;
      end else if (start_grant) begin
         rd_gnt <= ~grant_dir;
         wr_gnt <= grant_dir;
         wd_cnt <= 16'd0;
         if (grant_dir)
            wr_grant_cnt <= wr_grant_cnt + 16'd1;
         else
            rd_grant_cnt <= rd_grant_cnt + 16'd1;
      end else if (release_gnt) begin
         rd_gnt <= 1'b0;
         wr_gnt <= 1'b0;
      end else if (in_grant) begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end

   // Sticky watchdog flag; an expiry in the same cycle as a clear leaves it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timeout <= 1'b0;
      else if (wd_expire)
         timeout <= 1'b1;
      else if (timeout_clr)
         timeout <= 1'b0;
   end

endmodule

// File: tb/tb_slfifo_dir_arbiter.sv
// Purpose: directed self-checking bench for slfifo_dir_arbiter (TURN_CYCLES=4, MAX_GRANT_CYCLES=16).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: requests held as levels, done pulses driven for exactly one cycle.
module tb_slfifo_dir_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req, wr_req, rd_done, wr_done, timeout_clr;
   logic        data_dir, rd_gnt, wr_gnt, busy, timeout;
   logic [15:0] rd_grant_cnt, wr_grant_cnt;

   int checks   = 0;
   int failures = 0;

   slfifo_dir_arbiter #(
      .TURN_CYCLES      (4),
      .MAX_GRANT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_req       (rd_req),
      .wr_req       (wr_req),
      .rd_done      (rd_done),
      .wr_done      (wr_done),
      .timeout_clr  (timeout_clr),
      .data_dir     (data_dir),
      .rd_gnt       (rd_gnt),
      .wr_gnt       (wr_gnt),
      .busy         (busy),
      .timeout      (timeout),
      .rd_grant_cnt (rd_grant_cnt),
      .wr_grant_cnt (wr_grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Grants must never overlap, and must be low whenever data_dir changes.
   logic prev_dir = 1'b0;
   always @(negedge clk) begin
      chk("gnt_excl", 32'(rd_gnt & wr_gnt), 32'd0);
      if (data_dir !== prev_dir)
         chk("gnt_on_dir_change", 32'(rd_gnt | wr_gnt), 32'd0);
      prev_dir = data_dir;
   end

   initial begin
      logic d;
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_done = 1'b0; wr_done = 1'b0; timeout_clr = 1'b0;
      step(2);
      chk("rst_dir",     32'(data_dir), 32'd0);
      chk("rst_rd_gnt",  32'(rd_gnt), 32'd0);
      chk("rst_wr_gnt",  32'(wr_gnt), 32'd0);
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_rd_cnt",  32'(rd_grant_cnt), 32'd0);
      chk("rst_wr_cnt",  32'(wr_grant_cnt), 32'd0);
      rst = 1'b0;
      step(1);

      // Read only, same direction: one-cycle grant latency.
      rd_req = 1'b1;
      step(1);
      chk("t1_rd_gnt", 32'(rd_gnt), 32'd1);
      chk("t1_dir",    32'(data_dir), 32'd0);
      chk("t1_busy",   32'(busy), 32'd1);
      chk("t1_rd_cnt", 32'(rd_grant_cnt), 32'd1);
      rd_req = 1'b0; rd_done = 1'b1;
      step(1);
      rd_done = 1'b0;
      chk("t1_rel",  32'(rd_gnt), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);

      // Write only: direction flips first, grant after the 4-cycle turn.
      wr_req = 1'b1;
      step(1);
      chk("t2_dir",    32'(data_dir), 32'd1);
      chk("t2_busy",   32'(busy), 32'd1);
      chk("t2_gap_wr", 32'(wr_gnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("t2_gap_wr", 32'(wr_gnt), 32'd0);
         chk("t2_gap_rd", 32'(rd_gnt), 32'd0);
      end
      step(1);
      chk("t2_wr_gnt", 32'(wr_gnt), 32'd1);
      chk("t2_rd_gnt", 32'(rd_gnt), 32'd0);
      chk("t2_wr_cnt", 32'(wr_grant_cnt), 32'd1);
      wr_req = 1'b0; wr_done = 1'b1;
      step(1);
      wr_done = 1'b0;
      chk("t2_rel", 32'(wr_gnt), 32'd0);

      // Both requesting: alternate R,W,R,W with a turn before each grant.
      rd_req = 1'b1; wr_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d = ((k % 2) == 1);
         step(1);
         chk("t3_turn_dir", 32'(data_dir), 32'(d));
         chk("t3_gap", 32'(rd_gnt | wr_gnt), 32'd0);
         for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t3_gap", 32'(rd_gnt | wr_gnt), 32'd0);
         end
         step(1);
         chk("t3_rd_gnt", 32'(rd_gnt), 32'(!d));
         chk("t3_wr_gnt", 32'(wr_gnt), 32'(d));
         step(7);
         chk("t3_hold", 32'(d ? wr_gnt : rd_gnt), 32'd1);
         if (d) wr_done = 1'b1; else rd_done = 1'b1;
         if (k == 3) begin rd_req = 1'b0; wr_req = 1'b0; end
         step(1);
         rd_done = 1'b0; wr_done = 1'b0;
         chk("t3_rel", 32'(rd_gnt | wr_gnt), 32'd0);
         if (d) begin
            chk("t3_rd_cnt", 32'(rd_grant_cnt), 32'(2 + k / 2));
            chk("t3_wr_cnt", 32'(wr_grant_cnt), 32'(2 + k / 2));
         end
      end

      // Turn back to read, then abandon a write turn mid-way.
      rd_req = 1'b1;
      step(1);
      chk("t4_dir0", 32'(data_dir), 32'd0);
      step(4);
      chk("t4_rd_gnt", 32'(rd_gnt), 32'd1);
      chk("t4_rd_cnt", 32'(rd_grant_cnt), 32'd4);
      rd_req = 1'b0; rd_done = 1'b1;
      step(1);
      rd_done = 1'b0;
      wr_req = 1'b1;
      step(1);
      chk("t4_dir1", 32'(data_dir), 32'd1);
      wr_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("t4_no_wr_gnt", 32'(wr_gnt), 32'd0);
      end
      step(1);
      chk("t4_no_wr_gnt", 32'(wr_gnt), 32'd0);
      chk("t4_idle",      32'(busy), 32'd0);
      chk("t4_dir_kept",  32'(data_dir), 32'd1);
      chk("t4_wr_cnt",    32'(wr_grant_cnt), 32'd3);
      step(1);
      chk("t4_still_idle", 32'(busy | wr_gnt), 32'd0);

      // Watchdog: read grant without done lasts exactly 16 cycles.
      rd_req = 1'b1;
      step(1);
      chk("t5_dir0", 32'(data_dir), 32'd0);
      step(4);
      chk("t5_rd_gnt", 32'(rd_gnt), 32'd1);
      chk("t5_rd_cnt", 32'(rd_grant_cnt), 32'd5);
      rd_req = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(1);
         chk("t5_wd_hold", 32'(rd_gnt), 32'd1);
      end
      chk("t5_no_to_yet", 32'(timeout), 32'd0);
      step(1);
      chk("t5_wd_drop", 32'(rd_gnt), 32'd0);
      chk("t5_timeout", 32'(timeout), 32'd1);
      chk("t5_idle",    32'(busy), 32'd0);
      timeout_clr = 1'b1;
      step(1);
      timeout_clr = 1'b0;
      chk("t5_to_clr", 32'(timeout), 32'd0);

      // Done on the final watchdog cycle wins over expiry.
      rd_req = 1'b1;
      step(1);
      chk("t5b_rd_gnt", 32'(rd_gnt), 32'd1);
      chk("t5b_rd_cnt", 32'(rd_grant_cnt), 32'd6);
      rd_req = 1'b0;
      step(15);
      chk("t5b_hold", 32'(rd_gnt), 32'd1);
      rd_done = 1'b1;
      step(1);
      rd_done = 1'b0;
      chk("t5b_rel",   32'(rd_gnt), 32'd0);
      chk("t5b_no_to", 32'(timeout), 32'd0);

      // Clear coincident with expiry: timeout must end up set.
      rd_req = 1'b1;
      step(1);
      chk("t5c_rd_cnt", 32'(rd_grant_cnt), 32'd7);
      rd_req = 1'b0;
      step(15);
      timeout_clr = 1'b1;
      step(1);
      timeout_clr = 1'b0;
      chk("t5c_timeout", 32'(timeout), 32'd1);
      chk("t5c_drop",    32'(rd_gnt), 32'd0);

      // Asynchronous reset mid-grant, then a tie must go to read.
      rd_req = 1'b1;
      step(1);
      chk("t6_rd_gnt", 32'(rd_gnt), 32'd1);
      chk("t6_rd_cnt", 32'(rd_grant_cnt), 32'd8);
      rst = 1'b1;
      #1;
      chk("t6_rst_rd_gnt",  32'(rd_gnt), 32'd0);
      chk("t6_rst_busy",    32'(busy), 32'd0);
      chk("t6_rst_timeout", 32'(timeout), 32'd0);
      chk("t6_rst_rd_cnt",  32'(rd_grant_cnt), 32'd0);
      chk("t6_rst_wr_cnt",  32'(wr_grant_cnt), 32'd0);
      chk("t6_rst_dir",     32'(data_dir), 32'd0);
      step(1);
      rst = 1'b0;
      wr_req = 1'b1;
      step(1);
      chk("t6_tie_rd_gnt", 32'(rd_gnt), 32'd1);
      chk("t6_tie_wr_gnt", 32'(wr_gnt), 32'd0);
      chk("t6_tie_rd_cnt", 32'(rd_grant_cnt), 32'd1);
      chk("t6_tie_wr_cnt", 32'(wr_grant_cnt), 32'd0);
      rd_req = 1'b0; wr_req = 1'b0; rd_done = 1'b1;
      step(1);
      rd_done = 1'b0;
      chk("t6_rel", 32'(rd_gnt), 32'd0);
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
